// File: rtl/bus_pkg.sv
// Shared definitions for bus_device_endpoint: address width, broadcast id and destination
// extraction.
package bus_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PKT_W_MAX = 64;

  localparam logic [ADDR_W-1:0] BROADCAST_DEFAULT = '1;

  // Packets narrower than PKT_W_MAX are passed zero-extended; pkt_w gives the real width.
  function automatic logic [ADDR_W-1:0] get_dest(input logic [PKT_W_MAX-1:0] pkt,
                                                 input int unsigned         pkt_w);
    return pkt[pkt_w-1 -: ADDR_W];
  endfunction

endpackage

// File: rtl/bus_device_endpoint_if.sv
// Host and bus side signals of one bus_device_endpoint. The master modport drives the
// endpoint (host agent plus bus arbiter); the slave modport is the endpoint itself.
interface bus_device_endpoint_if #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8
);

  logic                     tx_valid;
  logic [pckg_sz-1:0]       tx_data;
  logic                     tx_ready;
  logic                     pndng;
  logic [pckg_sz-1:0]       D_pop;
  logic                     pop;
  logic                     push;
  logic [pckg_sz-1:0]       D_push;
  logic                     rx_valid;
  logic [pckg_sz-1:0]       rx_data;
  logic                     rx_rd;
  logic [$clog2(depth):0]   tx_count;
  logic [$clog2(depth):0]   rx_count;
  logic [7:0]               rx_drop_cnt;
  logic                     pop_err;

  modport master (
    output tx_valid, tx_data, pop, push, D_push, rx_rd,
    input  tx_ready, pndng, D_pop, rx_valid, rx_data, tx_count, rx_count, rx_drop_cnt, pop_err
  );

  modport slave (
    input  tx_valid, tx_data, pop, push, D_push, rx_rd,
    output tx_ready, pndng, D_pop, rx_valid, rx_data, tx_count, rx_count, rx_drop_cnt, pop_err
  );

endinterface

// File: rtl/endpoint_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit occupancy count, so that full
// and empty are distinguished when the wrapping pointers are equal.
module endpoint_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [Width-1:0]       wr_data,
  input  logic                   rd,
  output logic [Width-1:0]       rd_data,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/bus_device_endpoint.sv
// Device-side bus endpoint: tx FIFO drained by the bus via pndng/pop, rx FIFO filled via push.
// Destination filtering on rx is enabled by defining ENDPOINT_ADDR_FILTER_EN.
module bus_device_endpoint
  import bus_pkg::*;
#(
  parameter int unsigned       pckg_sz   = 16,
  parameter int unsigned       depth     = 8,
  parameter logic [ADDR_W-1:0] id        = '0,
  parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  bus_device_endpoint_if.slave bus
);

`ifdef ENDPOINT_ADDR_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  logic              ready_en_q;
  logic              pop_err_q;
  logic [7:0]        drop_q;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_wr, tx_rd, rx_wr, rx_rd_en;
  logic [ADDR_W-1:0] dest;
  logic              dest_hit, dest_match;

  // tx_ready is held low through reset and rises on the first clock after release.
  always_ff @(posedge clk) begin
    if (reset) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  assign bus.tx_ready = ready_en_q && !tx_full;
  assign bus.pndng    = !tx_empty;
  assign tx_wr        = bus.tx_valid && bus.tx_ready;
  assign tx_rd        = bus.pop && bus.pndng;

  endpoint_fifo #(
    .Width (pckg_sz),
    .Depth (depth)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (bus.tx_data),
    .rd      (tx_rd),
    .rd_data (bus.D_pop),
    .count   (bus.tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_err_q <= 1'b0;
    end else if (bus.pop && !bus.pndng) begin
      pop_err_q <= 1'b1;
    end
  end

  assign dest       = get_dest(PKT_W_MAX'(bus.D_push), pckg_sz);
  assign dest_hit   = (dest == id) || (dest == broadcast);
  assign dest_match = FilterEn ? dest_hit : 1'b1;

  // Full is the registered state, so a push on full drops even when rx_rd frees a slot.
  assign rx_wr    = bus.push && dest_match && !rx_full;
  assign rx_rd_en = bus.rx_rd && !rx_empty;

  endpoint_fifo #(
    .Width (pckg_sz),
    .Depth (depth)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .wr_data (bus.D_push),
    .rd      (rx_rd_en),
    .rd_data (bus.rx_data),
    .count   (bus.rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (bus.push && dest_match && rx_full && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.rx_valid    = !rx_empty;
  assign bus.rx_drop_cnt = drop_q;
  assign bus.pop_err     = pop_err_q;

endmodule

// File: doc/bus_device_endpoint.md
# bus_device_endpoint

Device-side endpoint of the `bs_gnrtr_n_rbtr` shared-bus protocol: the far end of the pop/pndng and push/D_push handshakes the bus generator/arbiter drives. It holds a transmit FIFO that the bus drains through `pndng`/`pop`/`D_pop`. It also holds a receive FIFO that the bus fills through `push`/`D_push`, with destination filtering against the device id and the broadcast id. One instance per device (`drvrs` instances) sits between a host agent and one bus port.

## Interface
- `pckg_sz`, 16, packet width; destination field is `[pckg_sz-1 : pckg_sz-8]`
- `depth`, 8, entries per FIFO; power of two, ≥2
- `id`, 0, this device's 8-bit destination id
- `broadcast`, `{8{1'b1}}`, destination value accepted by every device
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  **synchronous, active-high** reset
- `tx_valid`  in  1  host offers `tx_data`
- `tx_data`  in  pckg_sz  packet to transmit
- `tx_ready`  out  1  tx FIFO not full; write occurs on `tx_valid && tx_ready`
- `pndng`  out  1  tx FIFO non-empty (to bus)
- `D_pop`  out  pckg_sz  tx FIFO head, first-word-fall-through (to bus)
- `pop`  in  1  bus consumes head
- `push`  in  1  bus delivers `D_push`
- `D_push`  in  pckg_sz  delivered packet
- `rx_valid`  out  1  rx FIFO non-empty
- `rx_data`  out  pckg_sz  rx FIFO head, FWFT
- `rx_rd`  in  1  host consumes rx head
- `tx_count`, `rx_count`  out  $clog2(depth)+1  occupancy
- `rx_drop_cnt`  out  8  saturating count of pushes dropped on rx full
- `pop_err`  out  1  sticky: `pop` seen while `pndng`=0

## Operation
- Reset values: counts 0, pointers 0, `pndng`=0, `rx_valid`=0, `rx_drop_cnt`=0, `pop_err`=0, `D_pop`/`rx_data` don't-care. `tx_ready`=0 while `reset` is high and 1 in the first cycle after.
- Reset mid-operation empties both FIFOs in one cycle. In-flight `pop`/`push` during reset are ignored.
- TX:
  - Write on `tx_valid && tx_ready`.
  - Pop on `pop && pndng`; head advances.
  - Simultaneous write and pop when non-empty: count unchanged.
  - `pop` while empty: no state change, `pop_err` set.
- RX accept condition: `push` and destination match (`D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`) and not full.
- RX full is judged on the registered count before this cycle's `rx_rd`. A push on full is therefore dropped even if `rx_rd` is asserted that same cycle.
- A drop increments `rx_drop_cnt`, saturating at 255.
- `rx_rd` while empty is ignored.
- Non-matching pushes are silently discarded and not counted.
- Pointers wrap modulo `depth`. Count is held separately, so full and empty are distinguished at equal pointers.

## Timing
- Status outputs (`pndng`, `tx_ready`, `rx_valid`, counts) derive from registered state only; no input-to-output combinational path.
- Write-to-`pndng` latency is 1 cycle. A word written at edge N is visible on `D_pop` after edge N and can be popped at edge N+1.
- Write into an empty FIFO plus `pop` in the same cycle: the pop is ignored (`pndng` was 0) and `pop_err` is set.
- Push-to-`rx_valid` latency is 1 cycle.
- Back-to-back pops and pushes are sustained at one per cycle.

## Configuration
- `ENDPOINT_ADDR_FILTER_EN` defined: destination filtering as above.
- Undefined: every `push` is accepted subject only to rx full. `id` and `broadcast` are unused.

## Structure
- Shared package `bus_pkg`:
  - `ADDR_W`=8.
  - Function `get_dest(pkt)` returning the top `ADDR_W` bits.
  - Default broadcast constant.
- Sub-module `endpoint_fifo`: synchronous FWFT FIFO with count and wrap, instantiated twice (tx and rx). Filtering and drop counting live in the top level.

## Test plan
- Reset with 3 words queued → `tx_count`=0, `pndng`=0, `rx_valid`=0 the cycle after reset; `tx_ready`=1 after release.
- Write 0x0A11, 0x0B22, 0x0C33 then pop three consecutive cycles → `D_pop` shows 0x0A11, 0x0B22, 0x0C33 in order; `pndng` falls after the third pop.
- Fill tx to 8 → `tx_ready`=0. Then write and pop in the same cycle → `tx_count` stays 8 after the pop frees a slot and the next write completes. `pop` on empty → `pop_err`=1.
- `id`=2, filter enabled, push 0x0255, 0xFF66, 0x0377 → rx receives 0x0255 and 0xFF66 only; `rx_count`=2.
- Rx full (8), push 0x02AA with `rx_rd`=1 → dropped, `rx_drop_cnt`=1, `rx_count`=7. 300 drops → `rx_drop_cnt`=255.
- Filter compiled out, push 0x0377 to `id`=2 → accepted, `rx_data`=0x0377.
